// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fifo
//  Brief    : Fetch-group instruction FIFO between fetch and decode. Holds up
//             to DEPTH groups of four (pc, inst) slots plus a slot-valid mask
//             and the branch-prediction flag/target. Head entry is presented
//             combinationally; flush and reset empty the queue.
//  Config   : IFIFO_EARLY_FULL_EN -- when defined, full_ififo asserts one
//             entry early (count >= DEPTH-1) so a group already in flight
//             while the PC is held still has a free slot.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_ififo,
  input  logic                     push_valid,
  input  logic [3:0][31:0]         pc_in,
  input  logic [3:0][31:0]         inst_in,
  input  logic [3:0]               slot_valid_in,
  input  logic                     pred_in,
  input  logic [31:0]              pred_target_in,
  input  logic                     ready_dec,
  output logic                     full_ififo,
  output logic                     out_valid,
  output logic [3:0][31:0]         pc_out,
  output logic [3:0][31:0]         inst_out,
  output logic [3:0]               slot_valid_out,
  output logic                     pred_out,
  output logic [31:0]              pred_target_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  // Storage array: deliberately not reset, validity is tracked by count_q.
  logic [3:0][31:0] pc_mem_q   [DEPTH];
  logic [3:0][31:0] inst_mem_q [DEPTH];
  logic [3:0]       vld_mem_q  [DEPTH];
  logic             pred_mem_q [DEPTH];
  logic [31:0]      tgt_mem_q  [DEPTH];

  logic             w_push_fire;
  logic             w_pop_fire;
  logic             w_not_empty;

  // Acceptance is always bounded by real capacity; the early-full flag only
  // throttles the PC generator and never rejects a group that still fits.
  assign w_not_empty = (count_q != '0);
  assign w_push_fire = push_valid && !flush_ififo && (count_q < CW'(DEPTH));
  assign w_pop_fire  = w_not_empty && ready_dec && !flush_ififo;

  // Next-state pointers and occupancy; flush dominates push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_ififo) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_push_fire) tail_d = tail_q + AW'(1);
      if (w_pop_fire)  head_d = head_q + AW'(1);
      case ({w_push_fire, w_pop_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write the accepted group at the tail slot.
  always_ff @(posedge clk) begin
    if (w_push_fire && !rst) begin
      pc_mem_q[tail_q]   <= pc_in;
      inst_mem_q[tail_q] <= inst_in;
      vld_mem_q[tail_q]  <= slot_valid_in;
      pred_mem_q[tail_q] <= pred_in;
      tgt_mem_q[tail_q]  <= pred_target_in;
    end
  end

`ifdef IFIFO_EARLY_FULL_EN
  assign full_ififo = (count_q >= CW'(DEPTH - 1));
`else
  assign full_ififo = (count_q == CW'(DEPTH));
`endif

  // Head entry is exposed directly; mask and flag are qualified so an empty
  // FIFO never advertises valid slots or a stale prediction.
  assign out_valid       = w_not_empty;
  assign count           = count_q;
  assign pc_out          = pc_mem_q[head_q];
  assign inst_out        = inst_mem_q[head_q];
  assign pred_target_out = tgt_mem_q[head_q];
  assign slot_valid_out  = w_not_empty ? vld_mem_q[head_q] : 4'b0000;
  assign pred_out        = w_not_empty ? pred_mem_q[head_q] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_inst_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fifo
//  Brief    : Self-checking bench for inst_fifo. A queue of groups models the
//             FIFO; directed scenarios are followed by random traffic.
//  Config   : honours IFIFO_EARLY_FULL_EN for the expected full flag.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_ififo;
  logic             push_valid;
  logic [3:0][31:0] pc_in;
  logic [3:0][31:0] inst_in;
  logic [3:0]       slot_valid_in;
  logic             pred_in;
  logic [31:0]      pred_target_in;
  logic             ready_dec;
  logic             full_ififo;
  logic             out_valid;
  logic [3:0][31:0] pc_out;
  logic [3:0][31:0] inst_out;
  logic [3:0]       slot_valid_out;
  logic             pred_out;
  logic [31:0]      pred_target_out;
  logic [CW-1:0]    count;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_ififo(flush_ififo), .push_valid(push_valid),
    .pc_in(pc_in), .inst_in(inst_in), .slot_valid_in(slot_valid_in),
    .pred_in(pred_in), .pred_target_in(pred_target_in), .ready_dec(ready_dec),
    .full_ififo(full_ififo), .out_valid(out_valid), .pc_out(pc_out),
    .inst_out(inst_out), .slot_valid_out(slot_valid_out), .pred_out(pred_out),
    .pred_target_out(pred_target_out), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] pc;
    logic [127:0] inst;
    logic [3:0]   vld;
    logic         pred;
    logic [31:0]  tgt;
  } grp_t;

  grp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_outputs();
    int   sz;
    logic exp_full;
    sz = q.size();
`ifdef IFIFO_EARLY_FULL_EN
    exp_full = (sz >= DEPTH - 1);
`else
    exp_full = (sz == DEPTH);
`endif
    check_val("count", 128'(count), 128'(sz));
    check_val("out_valid", 128'(out_valid), 128'(sz != 0));
    check_val("full_ififo", 128'(full_ififo), 128'(exp_full));
    if (sz != 0) begin
      check_val("pc_out", pc_out, q[0].pc);
      check_val("inst_out", inst_out, q[0].inst);
      check_val("slot_valid_out", 128'(slot_valid_out), 128'(q[0].vld));
      check_val("pred_out", 128'(pred_out), 128'(q[0].pred));
      check_val("pred_target_out", 128'(pred_target_out), 128'(q[0].tgt));
    end else begin
      check_val("slot_valid_out_empty", 128'(slot_valid_out), 128'(0));
      check_val("pred_out_empty", 128'(pred_out), 128'(0));
    end
  endtask

  // Check current state, advance the model by the applied inputs, clock once.
  task automatic step();
    grp_t g;
    bit   do_push;
    bit   do_pop;
    check_outputs();
    g.pc = pc_in; g.inst = inst_in; g.vld = slot_valid_in;
    g.pred = pred_in; g.tgt = pred_target_in;
    if (rst || flush_ififo) begin
      q.delete();
    end else begin
      do_push = push_valid && (q.size() < DEPTH);
      do_pop  = ready_dec && (q.size() != 0);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(g);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(input logic [31:0] base, input logic [3:0] mask);
    for (int k = 0; k < 4; k++) begin
      pc_in[k]   = base + 32'(4 * k);
      inst_in[k] = $urandom;
    end
    slot_valid_in  = mask;
    pred_in        = 1'($urandom);
    pred_target_in = $urandom;
  endtask

  task automatic fill_to(input int n);
    push_valid = 1'b1; ready_dec = 1'b0; flush_ififo = 1'b0;
    while (q.size() < n) begin
      set_group($urandom, 4'($urandom));
      step();
    end
    push_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush_ififo = 1'b0; push_valid = 1'b0; ready_dec = 1'b0;
    set_group(32'h0, 4'h0);
    @(posedge clk);
    #1;
    q.delete();
    step();
    rst = 1'b0;

    // Eight pushes fill the FIFO, a ninth is dropped, drain in order.
    push_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_group(32'h1c000000 + 32'(16 * k), 4'hf);
      step();
    end
    check_val("fill_count", 128'(count), 128'(8));
`ifndef IFIFO_EARLY_FULL_EN
    check_val("fill_full", 128'(full_ififo), 128'(1));
`endif
    set_group(32'h2c000000, 4'hf);
    step();
    check_val("drop_count", 128'(count), 128'(8));
    push_valid = 1'b0; ready_dec = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_val("drain_pc", 128'(pc_out[0]), 128'(32'h1c000000 + 32'(16 * k)));
      step();
    end
    step();

    // Single push through an always-ready decoder.
    set_group(32'h1c000040, 4'b0011);
    push_valid = 1'b1;
    step();
    push_valid = 1'b0;
    check_val("single_valid", 128'(out_valid), 128'(1));
    check_val("single_pc", 128'(pc_out[0]), 128'(32'h1c000040));
    check_val("single_mask", 128'(slot_valid_out), 128'(4'b0011));
    step();
    check_val("single_gone", 128'(out_valid), 128'(0));
    check_val("single_count", 128'(count), 128'(0));

    // Steady push+pop at count 3 wraps the pointers.
    fill_to(3);
    push_valid = 1'b1; ready_dec = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_group($urandom, 4'($urandom));
      step();
    end
    check_val("steady_count", 128'(count), 128'(3));

    // Flush beats simultaneous push and pop.
    fill_to(5);
    push_valid = 1'b1; ready_dec = 1'b1; flush_ififo = 1'b1;
    step();
    flush_ififo = 1'b0; ready_dec = 1'b0;
    check_val("flush_count", 128'(count), 128'(0));
    check_val("flush_valid", 128'(out_valid), 128'(0));
    set_group(32'h1c000800, 4'b0111);
    step();
    push_valid = 1'b0;
    check_val("post_flush_pc", 128'(pc_out[0]), 128'(32'h1c000800));

`ifdef IFIFO_EARLY_FULL_EN
    // Early full: asserts at DEPTH-1, a push is still taken.
    fill_to(7);
    check_val("early_full7", 128'(full_ififo), 128'(1));
    fill_to(8);
    check_val("early_count8", 128'(count), 128'(8));
    ready_dec = 1'b1;
    step();
    ready_dec = 1'b0;
    check_val("early_count7", 128'(count), 128'(7));
    check_val("early_full_hold", 128'(full_ififo), 128'(1));
`endif

    // Reset mid-operation while pushing.
    flush_ififo = 1'b1; step(); flush_ififo = 1'b0;
    fill_to(6);
    push_valid = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; push_valid = 1'b0;
    check_val("rst_count", 128'(count), 128'(0));
    check_val("rst_valid", 128'(out_valid), 128'(0));
    check_val("rst_full", 128'(full_ififo), 128'(0));

    // Random traffic against the reference queue.
    for (int i = 0; i < 600; i++) begin
      set_group($urandom, 4'($urandom));
      push_valid  = ($urandom_range(0, 3) != 0);
      ready_dec   = ($urandom_range(0, 2) == 0);
      flush_ififo = ($urandom_range(0, 31) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; flush_ififo = 1'b0; push_valid = 1'b0; ready_dec = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
